iob_native_split: RTL and testbench

- Parametrised successor to the CPU-side bus glue.
- Takes one native valid/ready memory port, as driven by a PicoRV32-class core, and converts it into IOb handshakes (avalid/ready/rvalid) towards N_SLAVES peripherals.
- Routes by the top address bits; the address, write data and write strobe are broadcast to all slaves.
- Adds behaviour the previous glue lacked: registered one-hot per-slave avalid, explicit read/write FSM, bus-error response for unmapped selects, programmable watchdog timeout, and a sticky fault-address register.

---
 rtl/iob_native_split.sv | 189 ++++++++++++++++++
 tb/tb_iob_native_split.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_split.sv
// Native valid/ready CPU port to N_SLAVES IOb ports, routed by the top address bits.
// One access in flight; registered outputs; bus-error on unmapped select or watchdog expiry.
module iob_native_split #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned SEL_W    = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_valid,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_wstrb,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [N_SLAVES-1:0]        s_avalid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES-1:0]        s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [31:0] ToLast = 32'(TIMEOUT) - 32'd1;

  logic [1:0]          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [N_SLAVES-1:0] s_avalid_q, s_avalid_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_d;

  logic [SEL_W-1:0]    cpu_sel;
  logic                cpu_mapped;
  logic [N_SLAVES-1:0] req_onehot;
  logic                sel_rvalid;
  logic [DATA_W-1:0]   sel_rdata;
  logic                accept;
  logic                timed_out;

  assign cpu_sel    = cpu_addr[ADDR_W-1 -: SEL_W];
  assign cpu_mapped = 32'(cpu_sel) < 32'(N_SLAVES);
  assign accept     = (state_q == StReq) && |(s_avalid_q & s_ready);
  assign timed_out  = (TIMEOUT != 0) && (cnt_q >= ToLast);

  // Decode the incoming select and mux the latched slave's response.
  always_comb begin
    req_onehot = '0;
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (cpu_sel == SEL_W'(k)) req_onehot[k] = 1'b1;
      if (sel_q == SEL_W'(k)) begin
        sel_rvalid = s_rvalid[k];
        sel_rdata  = s_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    s_avalid_d  = s_avalid_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    err_addr_d  = err_addr_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_valid) begin
          s_addr_d  = cpu_addr;
          s_wdata_d = cpu_wdata;
          s_wstrb_d = cpu_wstrb;
          sel_d     = cpu_sel;
          if (!cpu_mapped) begin
            state_d     = StDone;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
            err_addr_d  = cpu_addr;
            if (cpu_wstrb == '0) cpu_rdata_d = '0;
          end else begin
            state_d    = StReq;
            s_avalid_d = req_onehot;
            cnt_d      = '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 32'd1;
        if (accept) begin
          s_avalid_d = '0;
          if (s_wstrb_q != '0) begin
            state_d     = StDone;
            cpu_ready_d = 1'b1;
          end else begin
            state_d = StRdWait;
          end
        end else if (timed_out) begin
          state_d     = StDone;
          s_avalid_d  = '0;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          err_addr_d  = s_addr_q;
          if (s_wstrb_q == '0) cpu_rdata_d = '0;
        end
      end
      StRdWait: begin
        cnt_d = cnt_q + 32'd1;
        if (sel_rvalid) begin
          state_d     = StDone;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = sel_rdata;
        end else if (timed_out) begin
          state_d     = StDone;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
          err_addr_d  = s_addr_q;
          cpu_rdata_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      s_avalid_q  <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      err_addr_q  <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      s_avalid_q  <= s_avalid_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_addr_q  <= err_addr_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign err_addr  = err_addr_q;
  assign s_avalid  = s_avalid_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;

endmodule

// File: tb/tb_iob_native_split.sv
// Table-driven bench for iob_native_split: a 2-slave instance with an 8-cycle watchdog
// and a 3-slave instance (2-bit select) for unmapped-select responses.
module tb_iob_native_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        which = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic [2:0]  s_ready = '0;
  logic [2:0]  s_rvalid = '0;
  logic [95:0] s_rdata = '0;

  logic [31:0] a_rdata, a_err_addr, a_s_addr, a_s_wdata;
  logic        a_ready, a_err;
  logic [1:0]  a_avalid;
  logic [3:0]  a_s_wstrb;
  logic [31:0] b_rdata, b_err_addr, b_s_addr, b_s_wdata;
  logic        b_ready, b_err;
  logic [2:0]  b_avalid;
  logic [3:0]  b_s_wstrb;

  always #5 clk = ~clk;

  iob_native_split #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(2), .SEL_W(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid & ~which), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(a_rdata), .cpu_ready(a_ready),
    .cpu_err(a_err), .err_addr(a_err_addr), .s_avalid(a_avalid), .s_addr(a_s_addr),
    .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_ready(s_ready[1:0]),
    .s_rvalid(s_rvalid[1:0]), .s_rdata(s_rdata[63:0])
  );

  iob_native_split #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .SEL_W(2), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid & which), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(b_rdata), .cpu_ready(b_ready),
    .cpu_err(b_err), .err_addr(b_err_addr), .s_avalid(b_avalid), .s_addr(b_s_addr),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_ready(s_ready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata)
  );

  // Views of whichever instance is under test.
  logic [2:0]  avalid_v;
  logic        ready_v, err_v;
  logic [31:0] rdata_v, err_addr_v, s_addr_v, s_wdata_v;
  logic [3:0]  s_wstrb_v;
  assign avalid_v   = which ? b_avalid : {1'b0, a_avalid};
  assign ready_v    = which ? b_ready : a_ready;
  assign err_v      = which ? b_err : a_err;
  assign rdata_v    = which ? b_rdata : a_rdata;
  assign err_addr_v = which ? b_err_addr : a_err_addr;
  assign s_addr_v   = which ? b_s_addr : a_s_addr;
  assign s_wdata_v  = which ? b_s_wdata : a_s_wdata;
  assign s_wstrb_v  = which ? b_s_wstrb : a_s_wstrb;

  typedef struct {
    logic        dut;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          sel;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] slv_data;
    logic        spur;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_err_addr;
    int          exp_av;
  } vec_t;

  localparam int NVEC = 11;
  localparam int NEVER = 1000;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plays one CPU access against a scripted slave; returns what the CPU saw.
  task automatic run_vec(input vec_t v, output int lat, output logic err,
                         output logic [31:0] rd, output int av_cnt, output int bad);
    bit   accepted = 0;
    int   wait_c = 0;
    int   since = 0;
    logic acc_now;
    logic is_rd;
    is_rd = (v.wstrb == 4'h0);
    @(posedge clk); #1;
    which     = v.dut;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_wstrb = v.wstrb;
    cpu_valid = 1'b1;
    s_ready   = '0;
    s_rvalid  = '0;
    for (int k = 0; k < 3; k++) s_rdata[k*32 +: 32] = (k == v.sel) ? v.slv_data : ~v.slv_data;
    lat = -1; err = 1'b0; rd = '0; av_cnt = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      acc_now = (v.sel < 3) && avalid_v[v.sel] && s_ready[v.sel];
      @(posedge clk); #1;
      if (acc_now) begin
        accepted = 1;
        since = 1;
      end else if (accepted) begin
        since++;
      end
      if (ready_v) begin
        lat = c; err = err_v; rd = rdata_v;
        break;
      end
      if (avalid_v != 3'b000) begin
        av_cnt++;
        if (avalid_v != (3'b001 << v.sel) || s_addr_v != v.addr || s_wdata_v != v.wdata ||
            s_wstrb_v != v.wstrb) bad++;
      end
      s_ready  = '0;
      s_rvalid = '0;
      if (!accepted && avalid_v != 3'b000) begin
        if (wait_c >= v.rdy_dly) s_ready[v.sel] = 1'b1;
        wait_c++;
      end
      if (accepted && is_rd && since == v.rv_dly) s_rvalid[v.sel] = 1'b1;
      if (v.spur) s_rvalid = s_rvalid | ~(3'b001 << v.sel);
    end
    cpu_valid = 1'b0;
    s_ready   = '0;
    s_rvalid  = '0;
  endtask

  initial begin
    int          lat, av_cnt, bad;
    logic        err;
    logic [31:0] rd;
    vec_t        v;
    bit          hit;

    //            dut   addr          wdata         strb  sel rdy    rv slv_data      spur lat err rdata         err_addr      av
    vecs[0]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0,     0, 32'h0,         1'b0, 2, 1'b0, 32'h0,        32'h0,        1};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 3,     2, 32'h1234_5678, 1'b0, 7, 1'b0, 32'h1234_5678, 32'h0,       4};
    vecs[2]  = '{1'b0, 32'h8000_0008, 32'h0,         4'h0, 1, 0,     1, 32'hA5A5_0001, 1'b0, 3, 1'b0, 32'hA5A5_0001, 32'h0,       1};
    vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0000_1111, 4'h3, 0, 0,     0, 32'h0,         1'b0, 2, 1'b0, 32'hA5A5_0001, 32'h0,       1};
    vecs[4]  = '{1'b0, 32'h8000_0040, 32'h0,         4'h0, 1, 1,     3, 32'h0BAD_F00D, 1'b1, 6, 1'b0, 32'h0BAD_F00D, 32'h0,       2};
    vecs[5]  = '{1'b0, 32'h8000_0100, 32'h0,         4'h0, 1, NEVER, 1, 32'h7777_7777, 1'b0, 9, 1'b1, 32'h0,        32'h8000_0100, 8};
    vecs[6]  = '{1'b0, 32'h8000_0300, 32'h0000_0003, 4'hF, 1, 6,     0, 32'h0,         1'b0, 8, 1'b0, 32'h0,        32'h8000_0100, 7};
    vecs[7]  = '{1'b0, 32'h0000_0200, 32'hFFFF_0000, 4'hF, 0, NEVER, 0, 32'h0,         1'b0, 9, 1'b1, 32'h0,        32'h0000_0200, 8};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 2, 0,     1, 32'h2222_2222, 1'b0, 3, 1'b0, 32'h2222_2222, 32'h0,       1};
    vecs[9]  = '{1'b1, 32'hC000_0004, 32'h1357_9BDF, 4'hF, 3, 0,     0, 32'h0,         1'b0, 1, 1'b1, 32'h2222_2222, 32'hC000_0004, 0};
    vecs[10] = '{1'b1, 32'hC000_0000, 32'h0,         4'h0, 3, 0,     1, 32'h0,         1'b0, 1, 1'b1, 32'h0,        32'hC000_0000, 0};

    // Reset state, both instances.
    #12;
    check("rst_a_avalid", 32'(a_avalid), 32'h0);
    check("rst_a_ready", 32'(a_ready), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_a_err_addr", a_err_addr, 32'h0);
    check("rst_b_avalid", 32'(b_avalid), 32'h0);
    check("rst_b_s_addr", b_s_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      v = vecs[i];
      run_vec(v, lat, err, rd, av_cnt, bad);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
      check($sformatf("v%0d_rdata", i), rd, v.exp_rdata);
      check($sformatf("v%0d_err_addr", i), err_addr_v, v.exp_err_addr);
      check($sformatf("v%0d_avalid_cycles", i), 32'(av_cnt), 32'(v.exp_av));
      check($sformatf("v%0d_bus_fields", i), 32'(bad), 32'h0);
      @(posedge clk); #1;
      check($sformatf("v%0d_single_pulse", i), 32'(ready_v), 32'h0);
      // After a watchdog abort, a late handshake from the slave must be ignored.
      if (v.exp_err && v.dut == 1'b0) begin
        s_ready[v.sel]  = 1'b1;
        s_rvalid[v.sel] = 1'b1;
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          check($sformatf("v%0d_late_avalid", i), 32'(avalid_v), 32'h0);
          check($sformatf("v%0d_late_ready", i), 32'(ready_v), 32'h0);
        end
        s_ready  = '0;
        s_rvalid = '0;
        check($sformatf("v%0d_late_rdata", i), rdata_v, v.exp_rdata);
      end
    end

    // Reset while slave 1 is being requested.
    @(posedge clk); #1;
    which     = 1'b0;
    cpu_addr  = 32'h8000_0000;
    cpu_wstrb = 4'h0;
    cpu_valid = 1'b1;
    hit = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (avalid_v == 3'b010) begin
        hit = 1;
        break;
      end
    end
    check("rstreq_reached_req", 32'(hit), 32'h1);
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    #1;
    check("rstreq_avalid", 32'(avalid_v), 32'h0);
    check("rstreq_ready", 32'(ready_v), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstreq_err_addr", err_addr_v, 32'h0);
    check("rstreq_rdata", rdata_v, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rstreq_no_ready", 32'(ready_v), 32'h0);
    end
    v = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 0, 1, 32'h5A5A_5A5A, 1'b0, 3, 1'b0,
          32'h5A5A_5A5A, 32'h0, 1};
    run_vec(v, lat, err, rd, av_cnt, bad);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_err", 32'(err), 32'h0);
    check("post_rst_rdata", rd, 32'h5A5A_5A5A);
    check("post_rst_avalid_cycles", 32'(av_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
